// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant; 1-cycle req->gnt latency.
// No backpressure: the owner holds until it drops req or the hold timeout forces rotation.
module rr_arb4 #(
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam bit                TMO_ON   = (MAX_HOLD != 0);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       release_w;
  logic       timeout_w;
  logic [3:0] idle_req;
  logic [3:0] rot_req;
  logic [2:0] win_idle;
  logic [2:0] win_rot;

  function automatic logic [3:0] dec(input logic [1:0] i);
    dec = 4'b0001 << i;
  endfunction

  // Returns {found, index} of the first set bit scanning s, s+1, s+2, s+3 (mod 4).
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] k;
    logic       hit;
    search = 3'b000;
    hit    = 1'b0;
    for (int n = 0; n < 4; n++) begin
      k = s + 2'(n);
      if (!hit && r[k]) begin
        hit    = 1'b1;
        search = {1'b1, k};
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;

    release_w = ~req[idx_q];
    timeout_w = TMO_ON && (hold_cnt_q == HOLD_LIM);
    // Gating with en keeps an undriven req bus out of the winner logic.
    idle_req  = en ? req : 4'b0000;
    rot_req   = en ? (req & ~(release_w ? dec(idx_q) : 4'b0000)) : 4'b0000;
    win_idle  = search(idle_req, ptr_q);
    win_rot   = search(rot_req, idx_q + 2'd1);

    case (state_q)
      IDLE: begin
        if (win_idle[2]) begin
          state_d    = GRANT;
          idx_d      = win_idle[1:0];
          gnt_d      = dec(win_idle[1:0]);
          hold_cnt_d = HOLD_ONE;
        end
      end
      GRANT: begin
        if (!release_w && !timeout_w) begin
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
          ptr_d = idx_q + 2'd1;
          if (win_rot[2]) begin
            idx_d      = win_rot[1:0];
            gnt_d      = dec(win_rot[1:0]);
            hold_cnt_d = HOLD_ONE;
          end else begin
            state_d    = IDLE;
            idx_d      = 2'd0;
            gnt_d      = 4'b0000;
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        idx_d      = 2'd0;
        gnt_d      = 4'b0000;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      idx_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: three instances (MAX_HOLD 16/0/4) share stimulus and are scored against a model.
module tb_rr_arb4;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] g  [NI];
  logic [1:0] gi [NI];
  logic       gv [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arb4 u_d16 (.clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(g[0]), .gnt_idx(gi[0]), .gnt_vld(gv[0]));
  rr_arb4 #(.HOLD_W(8), .MAX_HOLD(0)) u_d0 (.clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(g[1]), .gnt_idx(gi[1]), .gnt_vld(gv[1]));
  rr_arb4 #(.HOLD_W(8), .MAX_HOLD(4)) u_d4 (.clk(clk), .rst_n(rst_n), .en(en), .req(req), .gnt(g[2]), .gnt_idx(gi[2]), .gnt_vld(gv[2]));

  typedef struct packed {
    logic [NI-1:0][3:0] gnt;
    logic [NI-1:0][1:0] idx;
    logic [NI-1:0]      vld;
    logic [7:0]         cnt4;
    logic               busy4;
  } exp_t;

  exp_t sb[$];

  bit m_busy [NI];
  int m_ptr  [NI];
  int m_idx  [NI];
  int m_cnt  [NI];

  function automatic int mh(input int k);
    case (k)
      0:       return 16;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int scan(input logic [3:0] r, input int s);
    for (int n = 0; n < 4; n++) if (r[(s + n) % 4]) return (s + n) % 4;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0;
      m_ptr[k]  = 0;
      m_idx[k]  = 0;
      m_cnt[k]  = 0;
    end
    sb.delete();
  endtask

  task automatic model_step();
    int         o;
    int         w;
    bit         rel;
    bit         tmo;
    logic [3:0] cand;
    for (int k = 0; k < NI; k++) begin
      if (!m_busy[k]) begin
        if (en === 1'b1 && req != 4'b0000) begin
          m_idx[k]  = scan(req, m_ptr[k]);
          m_busy[k] = 1'b1;
          m_cnt[k]  = 1;
        end
      end else begin
        o   = m_idx[k];
        rel = (req[o] !== 1'b1);
        tmo = (mh(k) != 0) && (m_cnt[k] == mh(k));
        if (!rel && !tmo) begin
          m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        end else begin
          m_ptr[k] = (o + 1) % 4;
          cand = req;
          if (rel) cand[o] = 1'b0;
          w = (en === 1'b1) ? scan(cand, (o + 1) % 4) : -1;
          if (w >= 0) begin
            m_idx[k] = w;
            m_cnt[k] = 1;
          end else begin
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle, push the model's prediction, then score the DUT just after the edge.
  task automatic cyc(input logic [3:0] r, input logic e);
    exp_t x;
    exp_t y;
    @(negedge clk);
    req = r;
    en  = e;
    model_step();
    x = '0;
    for (int k = 0; k < NI; k++) begin
      x.gnt[k] = m_busy[k] ? 4'(1 << m_idx[k]) : 4'b0000;
      x.idx[k] = m_busy[k] ? 2'(m_idx[k]) : 2'd0;
      x.vld[k] = m_busy[k];
    end
    x.cnt4  = 8'(m_cnt[2]);
    x.busy4 = m_busy[2];
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("gnt[%0d]", k), 32'(g[k]), 32'(y.gnt[k]));
      check($sformatf("gnt_idx[%0d]", k), 32'(gi[k]), 32'(y.idx[k]));
      check($sformatf("gnt_vld[%0d]", k), 32'(gv[k]), 32'(y.vld[k]));
    end
    if (y.busy4) check("hold_cnt4", 32'(u_d4.hold_cnt_q), 32'(y.cnt4));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    en    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n_ord;
    int idle_cyc;
    int last;
    logic [3:0] r;

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    model_reset();
    #12;
    for (int k = 0; k < NI; k++) begin
      check("rst_gnt", 32'(g[k]), 32'h0);
      check("rst_vld", 32'(gv[k]), 32'h0);
      check("rst_idx", 32'(gi[k]), 32'h0);
    end
    check("rst_ptr", 32'(u_d16.ptr_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests.
    repeat (5) cyc(4'b0000, 1'b1);

    // Single requester 2, then release; pointer moves past it.
    do_reset();
    cyc(4'b0100, 1'b1);
    check("single_first", 32'(g[0]), 32'h4);
    repeat (2) cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);
    check("single_drop", 32'(g[0]), 32'h0);
    check("single_ptr", 32'(u_d16.ptr_q), 32'h3);

    // Fairness on the no-timeout instance: owner drops req after two grant cycles.
    do_reset();
    n_ord = 0;
    idle_cyc = 0;
    last = -1;
    for (int c = 0; c < 20 && n_ord < 5; c++) begin
      r = 4'hF;
      if (m_busy[1] && m_cnt[1] == 2) r[m_idx[1]] = 1'b0;
      cyc(r, 1'b1);
      if (!gv[1]) begin
        if (n_ord > 0) idle_cyc++;
      end else if (int'(gi[1]) != last || u_d0.hold_cnt_q == 8'd1) begin
        order[n_ord] = int'(gi[1]);
        n_ord++;
        last = int'(gi[1]);
      end
    end
    check("rr_count", 32'(n_ord), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    check("rr_idle", 32'(idle_cyc), 32'd0);

    // Timeout rotation between requesters 0 and 1 on the MAX_HOLD=4 instance.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0011, 1'b1);
      check($sformatf("tmo_owner%0d", i), 32'(gi[2]), (i >= 4 && i < 8) ? 32'd1 : 32'd0);
    end

    // Sole requester re-granted on timeout without a gap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(4'b1000, 1'b1);
      check($sformatf("sole_gnt%0d", i), 32'(g[2]), 32'h8);
      check($sformatf("sole_cnt%0d", i), 32'(u_d4.hold_cnt_q), 32'((i % 4) + 1));
    end

    // Enable gating and asynchronous reset mid-grant.
    do_reset();
    repeat (3) cyc(4'b0010, 1'b0);
    check("en_off", 32'(g[0]), 32'h0);
    cyc(4'b0010, 1'b1);
    check("en_on", 32'(g[0]), 32'h2);
    cyc(4'b0010, 1'b1);
    cyc(4'b0100, 1'b0);
    check("en_off_release", 32'(gv[0]), 32'h0);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b1);
    check("regrant", 32'(g[0]), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("async_gnt%0d", k), 32'(g[k]), 32'h0);
    check("async_ptr", 32'(u_d16.ptr_q), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Unknown requests while disabled must not reach the grant.
    repeat (3) cyc(4'bxxxx, 1'b0);
    check("x_gnt", 32'(g[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
